// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared definitions for the MIPS inter-stage pipeline registers:
//   nominal payload widths for each stage boundary, the NOP encoding used
//   as the bubble value, and the occupancy encodings of pipe_stage_reg.
package pipe_pkg;

    // Payload widths of the four stage boundaries.
    localparam int IFID_W  = 64;   // {instr, next_pc}
    localparam int IDEX_W  = 148;
    localparam int EXMEM_W = 107;
    localparam int MEMWB_W = 71;

    // sll $0,$0,0: an all-zero word decodes as a NOP.
    localparam logic [31:0] NOP_INSTR = 32'h0;

    // Number of entries held by a stage register.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_FULL  = 2'd1,
        OCC_BUSY  = 2'd2
    } occ_t;

endpackage

// File: rtl/pipe_entry.sv
// pipe_entry
//   One payload slot of a pipeline register: DATA_W data bits plus a valid
//   bit. An invalid slot always holds BUBBLE, so downstream logic that
//   decodes the data while valid is low sees a NOP.
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset (clears to BUBBLE)
//   load   in   capture dIn, set valid
//   clear  in   drop the payload (data <= BUBBLE, valid <= 0); wins over load
//   dIn    in   payload to capture
//   dOut   out  held payload
//   valid  out  slot holds a payload
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int                 DATA_W = 64,
    parameter logic [DATA_W-1:0]  BUBBLE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] dIn,
    output logic [DATA_W-1:0] dOut,
    output logic              valid
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            dOut  <= BUBBLE;
            valid <= 1'b0;
        end else if (load) begin
            dOut  <= dIn;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Inter-stage pipeline register with valid/ready handshake, stall hold,
//   flush-to-bubble and an optional skid entry (SKID=1) that lets in_ready
//   be a register with no combinational path from out_ready.
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake, in_data payload
//   out_valid/out_ready   downstream handshake, out_data payload
//   stall                 freeze contents; no accept/emit while high
//   flush                 drop all held payloads (beats stall)
//   occupancy             entries currently held (0..2)
//
// state     | meaning
// OCC_EMPTY | nothing held, out_data = BUBBLE
// OCC_FULL  | main entry holds the head payload
// OCC_BUSY  | main + skid both hold payloads (skid is younger); in_ready low
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W = 64,
    parameter bit                 SKID   = 1'b1,
    parameter logic [DATA_W-1:0]  BUBBLE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    occ_t              state, nextState;
    logic              inReadyReg;
    logic              accept, emit;
    logic              mainLoad, mainClear, mainSel;
    logic              skidLoad, skidClear;
    logic              mainValid, skidValid;
    logic [DATA_W-1:0] mainD, skidData;

    // Stall masks both handshakes, so nothing moves while it is high.
    assign out_valid = mainValid & ~stall;
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    // inReadyReg is 0 through reset and rises one cycle after release.
    generate
        if (SKID) begin : g_readySkid
            assign in_ready = inReadyReg & ~stall;
        end else begin : g_readySingle
            assign in_ready = inReadyReg & ~stall & (~mainValid | out_ready);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= OCC_EMPTY;
            inReadyReg <= 1'b0;
        end else begin
            state      <= nextState;
            inReadyReg <= (nextState != OCC_BUSY);
        end
    end

    always_comb begin
        nextState = state;
        mainLoad  = 1'b0;
        mainClear = 1'b0;
        mainSel   = 1'b0;
        skidLoad  = 1'b0;
        skidClear = 1'b0;
        if (flush) begin
            nextState = OCC_EMPTY;
            mainClear = 1'b1;
            skidClear = 1'b1;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (accept) begin
                        nextState = OCC_FULL;
                        mainLoad  = 1'b1;
                    end
                end
                OCC_FULL: begin
                    if (accept && emit) begin
                        mainLoad = 1'b1;
                    end else if (accept) begin
                        // Only reachable with SKID=1: single-entry in_ready needs out_ready.
                        nextState = OCC_BUSY;
                        skidLoad  = 1'b1;
                    end else if (emit) begin
                        nextState = OCC_EMPTY;
                        mainClear = 1'b1;
                    end
                end
                OCC_BUSY: begin
                    if (emit) begin
                        nextState = OCC_FULL;
                        mainLoad  = 1'b1;
                        mainSel   = 1'b1;
                        skidClear = 1'b1;
                    end
                end
                default: begin
                    nextState = OCC_EMPTY;
                    mainClear = 1'b1;
                    skidClear = 1'b1;
                end
            endcase
        end
    end

    assign mainD = mainSel ? skidData : in_data;

    pipe_entry #(.DATA_W(DATA_W), .BUBBLE(BUBBLE)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (mainLoad),
        .clear (mainClear),
        .dIn   (mainD),
        .dOut  (out_data),
        .valid (mainValid)
    );

    generate
        if (SKID) begin : g_skid
            pipe_entry #(.DATA_W(DATA_W), .BUBBLE(BUBBLE)) u_skid (
                .clk   (clk),
                .reset (reset),
                .load  (skidLoad),
                .clear (skidClear),
                .dIn   (in_data),
                .dOut  (skidData),
                .valid (skidValid)
            );
        end else begin : g_noSkid
            assign skidData  = BUBBLE;
            assign skidValid = 1'b0;
        end
    endgenerate

    assign occupancy = {1'b0, mainValid} + {1'b0, skidValid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int          W   = 16;
    localparam logic [W-1:0] BUB = 16'hF00D;

    logic         clk = 1'b0;
    logic         reset, inValid, outReady, stall, flush;
    logic [W-1:0] inData;
    logic         inReady  [2];
    logic         outValid [2];
    logic [W-1:0] outData  [2];
    logic [1:0]   occ      [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // index 0: single register, index 1: skid version
    pipe_stage_reg #(.DATA_W(W), .SKID(1'b0), .BUBBLE(BUB)) u_single (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady[0]),
        .in_data(inData), .out_valid(outValid[0]), .out_ready(outReady),
        .out_data(outData[0]), .stall(stall), .flush(flush), .occupancy(occ[0])
    );

    pipe_stage_reg #(.DATA_W(W), .SKID(1'b1), .BUBBLE(BUB)) u_skidreg (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady[1]),
        .in_data(inData), .out_valid(outValid[1]), .out_ready(outReady),
        .out_data(outData[1]), .stall(stall), .flush(flush), .occupancy(occ[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected payloads in order, per DUT.
    logic [W-1:0] sbq [2][$];
    bit started = 1'b0;
    bit alive   = 1'b0;

    always @(negedge clk) begin
        int           sz;
        logic         expOv, expIr;
        logic [W-1:0] expD;
        if (reset) begin
            sbq[0].delete();
            sbq[1].delete();
            alive   = 1'b0;
            started = 1'b1;
        end else if (started) begin
            for (int k = 0; k < 2; k++) begin
                sz    = sbq[k].size();
                expOv = (sz > 0) && !stall;
                expD  = (sz > 0) ? sbq[k][0] : BUB;
                if (k == 1) expIr = alive && !stall && (sz != 2);
                else        expIr = alive && !stall && ((sz == 0) || outReady);
                chk($sformatf("mon%0d out_valid", k), {31'b0, outValid[k]}, {31'b0, expOv});
                chk($sformatf("mon%0d out_data", k), {16'b0, outData[k]}, {16'b0, expD});
                chk($sformatf("mon%0d occupancy", k), {30'b0, occ[k]}, sz);
                chk($sformatf("mon%0d in_ready", k), {31'b0, inReady[k]}, {31'b0, expIr});
                if (flush) begin
                    sbq[k].delete();
                end else begin
                    if (expOv && outReady) void'(sbq[k].pop_front());
                    if (inValid && expIr)  sbq[k].push_back(inData);
                end
            end
            alive = 1'b1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; inValid = 1'b0; outReady = 1'b0; stall = 1'b0; flush = 1'b0; inData = '0;

        // 1: reset held two edges
        cyc(); cyc();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d out_valid", k), {31'b0, outValid[k]}, 0);
            chk($sformatf("rst%0d out_data", k), {16'b0, outData[k]}, {16'b0, BUB});
            chk($sformatf("rst%0d occupancy", k), {30'b0, occ[k]}, 0);
        end
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("rel in_ready first cycle", {31'b0, inReady[1]}, 0);
        cyc();
        @(negedge clk);
        chk("rel in_ready skid", {31'b0, inReady[1]}, 1);
        chk("rel in_ready single", {31'b0, inReady[0]}, 1);

        // 2: stream 1..8 with out_ready high
        outReady = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            inValid = 1'b1;
            inData  = W'(i);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (i > 1) begin
                    chk($sformatf("stream%0d data%0d", k, i - 1), {16'b0, outData[k]}, i - 1);
                    chk($sformatf("stream%0d occ", k), {30'b0, occ[k]}, 1);
                end
            end
        end
        cyc();
        inValid = 1'b0;
        @(negedge clk);
        chk("stream last data", {16'b0, outData[1]}, 8);
        cyc();
        @(negedge clk);
        chk("stream drained occ", {30'b0, occ[1]}, 0);

        // 3: fill main+skid with 0xA, 0xB, then drain in order
        cyc();
        outReady = 1'b0; inValid = 1'b1; inData = 16'h000A;
        cyc();
        inData = 16'h000B;
        @(negedge clk);
        chk("skid in_ready full", {31'b0, inReady[1]}, 1);
        chk("skid occ full", {30'b0, occ[1]}, 1);
        cyc();
        inValid = 1'b0;
        @(negedge clk);
        chk("skid occ busy", {30'b0, occ[1]}, 2);
        chk("skid in_ready busy", {31'b0, inReady[1]}, 0);
        cyc();
        outReady = 1'b1;
        @(negedge clk);
        chk("skid first out", {16'b0, outData[1]}, 16'h000A);
        cyc();
        @(negedge clk);
        chk("skid second out", {16'b0, outData[1]}, 16'h000B);
        cyc();
        @(negedge clk);
        chk("skid drained occ", {30'b0, occ[1]}, 0);

        // 4: stall holds 0x55 for three cycles
        cyc();
        outReady = 1'b0; inValid = 1'b1; inData = 16'h0055;
        cyc();
        inValid = 1'b0; stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("stall%0d out_valid", k), {31'b0, outValid[k]}, 0);
                chk($sformatf("stall%0d in_ready", k), {31'b0, inReady[k]}, 0);
            end
            cyc();
        end
        stall = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("unstall%0d out_valid", k), {31'b0, outValid[k]}, 1);
            chk($sformatf("unstall%0d out_data", k), {16'b0, outData[k]}, 16'h0055);
        end
        cyc();
        outReady = 1'b1;
        cyc();
        outReady = 1'b0;

        // 5: flush under stall while holding two entries
        inValid = 1'b1; inData = 16'h0011;
        cyc();
        inData = 16'h0022;
        cyc();
        inValid = 1'b0;
        @(negedge clk);
        chk("preflush occ", {30'b0, occ[1]}, 2);
        cyc();
        stall = 1'b1; flush = 1'b1; inValid = 1'b1; inData = 16'h0033;
        cyc();
        stall = 1'b0; flush = 1'b0; inValid = 1'b0;
        @(negedge clk);
        chk("flush occ", {30'b0, occ[1]}, 0);
        chk("flush out_data", {16'b0, outData[1]}, {16'b0, BUB});
        chk("flush in_ready", {31'b0, inReady[1]}, 1);
        chk("flush out_valid", {31'b0, outValid[1]}, 0);

        // 6: random traffic checked by the scoreboard
        for (int c = 0; c < 4000; c++) begin
            cyc();
            reset    = ($urandom_range(0, 999) < 3);
            flush    = ($urandom_range(0, 99) < 2);
            stall    = ($urandom_range(0, 99) < 15);
            inValid  = ($urandom_range(0, 99) < 70);
            outReady = ($urandom_range(0, 99) < 60);
            inData   = W'($urandom_range(0, 16'hEFFF));
        end
        cyc();
        reset = 1'b0; flush = 1'b0; stall = 1'b0; inValid = 1'b0; outReady = 1'b1;
        repeat (4) cyc();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
